// File: rtl/gpio_pkg.sv
// Shared constants, state encoding and helpers for the GPIO bus master.
// The RMW states exist only when GPIO_MASTER_RMW_EN is defined.
package gpio_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 4;

    localparam logic [1:0] GPIO_OUT_ADDR = 2'h0;
    localparam logic [1:0] GPIO_IN_ADDR  = 2'h1;

`ifdef GPIO_MASTER_RMW_EN
    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StWait,
        StResp,
        StRmwRd,
        StRmwWr
    } gpio_state_e;

    function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] wdata,
                                                    input logic [DATA_W-1:0] mask,
                                                    input logic [DATA_W-1:0] rdata);
        return (wdata & mask) | (rdata & ~mask);
    endfunction
`else
    typedef enum logic [2:0] {
        StIdle,
        StAccess,
        StWait,
        StResp
    } gpio_state_e;
`endif

    function automatic logic addr_legal(input logic [1:0] addr);
        return (addr == GPIO_OUT_ADDR) || (addr == GPIO_IN_ADDR);
    endfunction

endpackage

// File: rtl/gpio_wait_cnt.sv
// Loadable down-counter; done flags the final cycle of a read-latency wait.
module gpio_wait_cnt
    import gpio_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/gpio_bus_master.sv
// Valid/ready command front-end that drives the GPIO port bus and returns one response.
// Read-modify-write writes are compiled in with GPIO_MASTER_RMW_EN.
module gpio_bus_master
    import gpio_pkg::*;
#(
    parameter int unsigned       READ_LATENCY = 1,
    parameter logic [DATA_W-1:0] BASE_ADDR    = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef GPIO_MASTER_RMW_EN
    input  logic              req_rmw,
    input  logic [DATA_W-1:0] req_mask,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [DATA_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic              bus_sel,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(READ_LATENCY);

    gpio_state_e state_q, state_d;

    logic              cmd_write_q;
    logic [1:0]        cmd_addr_q;
    logic [DATA_W-1:0] cmd_wdata_q;
    logic              cmd_err_q;
    logic              rmw_op;

    logic              bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] resp_data;
    logic [DATA_W-1:0] sel_addr;

    logic accept;
    logic cnt_load, cnt_en, cnt_done;

`ifdef GPIO_MASTER_RMW_EN
    logic              cmd_rmw_q;
    logic [DATA_W-1:0] cmd_mask_q;
    logic [DATA_W-1:0] rd_q, rd_d;
    assign rmw_op = cmd_rmw_q;
`else
    assign rmw_op = 1'b0;
`endif

    assign req_ready = (state_q == StIdle) && !rst;
    assign accept    = req_valid && req_ready;
    assign sel_addr  = BASE_ADDR | {{(DATA_W-2){1'b0}}, cmd_addr_q};

    gpio_wait_cnt u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (WAIT_LOAD),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    // Bus and response registers follow the state by one cycle, so a read is sampled
    // READ_LATENCY cycles after the cycle in which bus_sel is visible.
    always_comb begin
        resp_data = '0;
        if (!cmd_err_q) begin
`ifdef GPIO_MASTER_RMW_EN
            if (rmw_op) begin
                resp_data = rd_q;
            end else if (!cmd_write_q) begin
                resp_data = bus_rdata;
            end
`else
            if (!cmd_write_q) begin
                resp_data = bus_rdata;
            end
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        bus_sel_d   = 1'b0;
        bus_addr_d  = '0;
        bus_wdata_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cnt_load    = 1'b0;
        cnt_en      = 1'b0;
`ifdef GPIO_MASTER_RMW_EN
        rd_d        = rd_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = addr_legal(req_addr) ? StAccess : StResp;
                end
            end
            StAccess: begin
                bus_sel_d  = 1'b1;
                bus_addr_d = sel_addr;
                if (cmd_write_q && !rmw_op) begin
                    bus_wdata_d = cmd_wdata_q;
                    state_d     = StResp;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = StWait;
                end
            end
            StWait: begin
                cnt_en = 1'b1;
                if (cnt_done) begin
`ifdef GPIO_MASTER_RMW_EN
                    state_d = rmw_op ? StRmwRd : StResp;
`else
                    state_d = StResp;
`endif
                end
            end
`ifdef GPIO_MASTER_RMW_EN
            StRmwRd: begin
                rd_d    = bus_rdata;
                state_d = StRmwWr;
            end
            StRmwWr: begin
                bus_sel_d   = 1'b1;
                bus_addr_d  = sel_addr;
                bus_wdata_d = rmw_merge(cmd_wdata_q, cmd_mask_q, rd_q);
                state_d     = StResp;
            end
`endif
            StResp: begin
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = cmd_err_q;
                    rsp_rdata_d = resp_data;
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    rsp_err_d   = 1'b0;
                    rsp_rdata_d = '0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            bus_sel_q   <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            bus_sel_q   <= bus_sel_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            cmd_err_q   <= 1'b0;
`ifdef GPIO_MASTER_RMW_EN
            cmd_rmw_q   <= 1'b0;
            cmd_mask_q  <= '0;
`endif
        end else if (accept) begin
            cmd_write_q <= req_write;
            cmd_addr_q  <= req_addr;
            cmd_wdata_q <= req_wdata;
            cmd_err_q   <= !addr_legal(req_addr);
`ifdef GPIO_MASTER_RMW_EN
            cmd_rmw_q   <= req_write && req_rmw;
            cmd_mask_q  <= req_mask;
`endif
        end
    end

`ifdef GPIO_MASTER_RMW_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end
`endif

    assign bus_sel   = bus_sel_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_gpio_bus_master.sv
// Bench for gpio_bus_master: per-cycle transaction model plus directed literal checks.
// RMW scenario runs only when GPIO_MASTER_RMW_EN is defined.
module tb_gpio_bus_master;

    localparam int unsigned RL   = 1;
    localparam logic [31:0] BASE = 32'h0;
    localparam logic [31:0] IDLE_DATA = 32'hBAD0_BAD0;
`ifdef GPIO_MASTER_RMW_EN
    localparam bit RMW_EN = 1'b1;
`else
    localparam bit RMW_EN = 1'b0;
`endif

    logic        clk, rst;
    logic        req_valid, req_ready, req_write, req_rmw;
    logic [1:0]  req_addr;
    logic [31:0] req_wdata, req_mask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata, bus_rdata;
    logic        bus_sel;

    int n_vec  = 0;
    int n_miss = 0;
    int cyc    = 0;
    logic [31:0] in_val;

    gpio_bus_master #(
        .READ_LATENCY (RL),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef GPIO_MASTER_RMW_EN
        .req_rmw   (req_rmw),
        .req_mask  (req_mask),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_miss = n_miss + 1;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // GPIO port: read data is presented only in the cycle after a Select cycle.
    initial begin
        logic        sel_seen;
        logic [31:0] addr_seen;
        bus_rdata = IDLE_DATA;
        forever begin
            @(negedge clk);
            sel_seen  = bus_sel;
            addr_seen = bus_addr;
            @(posedge clk);
            #1;
            if (sel_seen) bus_rdata = (addr_seen[1:0] == 2'd1) ? in_val : 32'h0;
            else          bus_rdata = IDLE_DATA;
        end
    end

    // Transaction-level model: each accepted command has fixed Select and response cycles.
    bit          m_busy = 1'b0;
    int          m_acc, m_rsp_at;
    logic        m_legal, m_write, m_rmw;
    logic [1:0]  m_addr;
    logic [31:0] m_wdata, m_rdata, m_wr2;

    initial begin
        logic        e_sel, e_rv, e_err;
        logic [31:0] e_addr, e_wd, e_rd;
        forever begin
            @(negedge clk);
            e_sel = 1'b0; e_addr = '0; e_wd = '0; e_rv = 1'b0; e_err = 1'b0; e_rd = '0;
            if (!rst && m_busy) begin
                if (m_legal && cyc == m_acc + 1) begin
                    e_sel  = 1'b1;
                    e_addr = BASE | {30'b0, m_addr};
                    e_wd   = (m_write && !m_rmw) ? m_wdata : 32'h0;
                end
                if (m_rmw && cyc == m_acc + 3 + RL) begin
                    e_sel  = 1'b1;
                    e_addr = BASE | {30'b0, m_addr};
                    e_wd   = m_wr2;
                end
                if (cyc >= m_rsp_at) begin
                    e_rv  = 1'b1;
                    e_err = !m_legal;
                    e_rd  = m_rdata;
                end
            end
            chk("model_req_ready", {31'b0, req_ready}, {31'b0, !rst && !m_busy});
            chk("model_bus_sel", {31'b0, bus_sel}, {31'b0, e_sel});
            chk("model_bus_addr", bus_addr, e_addr);
            chk("model_bus_wdata", bus_wdata, e_wd);
            chk("model_rsp_valid", {31'b0, rsp_valid}, {31'b0, e_rv});
            chk("model_rsp_err", {31'b0, rsp_err}, {31'b0, e_err});
            if (e_rv) chk("model_rsp_rdata", rsp_rdata, e_rd);
            // Decide what the coming clock edge does.
            if (rst) begin
                m_busy = 1'b0;
            end else if (m_busy) begin
                if (e_rv && rsp_ready) m_busy = 1'b0;
            end else if (req_valid) begin
                m_busy  = 1'b1;
                m_acc   = cyc + 1;
                m_addr  = req_addr;
                m_write = req_write;
                m_wdata = req_wdata;
                m_legal = (req_addr <= 2'd1);
                m_rmw   = RMW_EN && req_write && req_rmw && m_legal;
                m_wr2   = (req_wdata & req_mask) | (in_val & ~req_mask);
                if (!m_legal) begin
                    m_rdata  = 32'h0;
                    m_rsp_at = m_acc + 1;
                end else if (m_rmw) begin
                    m_rdata  = in_val;
                    m_rsp_at = m_acc + 4 + RL;
                end else if (req_write) begin
                    m_rdata  = 32'h0;
                    m_rsp_at = m_acc + 2;
                end else begin
                    m_rdata  = (req_addr == 2'd1) ? in_val : 32'h0;
                    m_rsp_at = m_acc + 2 + RL;
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Present a command; return 2ns after the accepting edge.
    task automatic send(input logic w, input logic [1:0] a, input logic [31:0] d,
                        input logic rmw, input logic [31:0] mask);
        int n;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
        req_rmw = rmw; req_mask = mask;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 40) begin
            n = n + 1;
            @(negedge clk);
        end
        chk("req_accept", {31'b0, req_ready}, 32'h1);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp;
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 40) begin
            n = n + 1;
            @(negedge clk);
        end
        chk("rsp_arrives", {31'b0, rsp_valid}, 32'h1);
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        req_rmw = 1'b0; req_mask = '0; rsp_ready = 1'b1; in_val = 32'h0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_req_ready", {31'b0, req_ready}, 32'h0);
        chk("reset_bus_sel", {31'b0, bus_sel}, 32'h0);
        chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_req_ready", {31'b0, req_ready}, 32'h1);

        // Plain write.
        tick();
        send(1'b1, 2'd0, 32'hA5, 1'b0, 32'h0);
        @(negedge clk); chk("wr_sel_n0", {31'b0, bus_sel}, 32'h0);
        @(negedge clk);
        chk("wr_sel_n1", {31'b0, bus_sel}, 32'h1);
        chk("wr_addr", bus_addr, 32'h0);
        chk("wr_wdata", bus_wdata, 32'hA5);
        @(negedge clk);
        chk("wr_rsp_valid_n2", {31'b0, rsp_valid}, 32'h1);
        chk("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk("wr_sel_n2", {31'b0, bus_sel}, 32'h0);
        @(negedge clk); chk("wr_ready_after", {31'b0, req_ready}, 32'h1);

        // Read with one cycle of latency.
        tick();
        in_val = 32'h3C;
        send(1'b0, 2'd1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("rd_addr", bus_addr, 32'h1);
        chk("rd_wdata_zero", bus_wdata, 32'h0);
        @(negedge clk); chk("rd_rsp_valid_n2", {31'b0, rsp_valid}, 32'h0);
        @(negedge clk);
        chk("rd_rsp_valid_n3", {31'b0, rsp_valid}, 32'h1);
        chk("rd_rsp_rdata", rsp_rdata, 32'h3C);

        // Backpressure with a competing command held on req_valid.
        tick(); tick();
        rsp_ready = 1'b0;
        in_val = 32'h1234_5678;
        send(1'b0, 2'd1, 32'h0, 1'b0, 32'h0);
        wait_rsp();
        tick();
        req_valid = 1'b1; req_write = 1'b1; req_addr = 2'd0; req_wdata = 32'h77;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_rsp_valid", {31'b0, rsp_valid}, 32'h1);
            chk("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
            chk("bp_req_ready", {31'b0, req_ready}, 32'h0);
        end
        tick();
        rsp_ready = 1'b1;
        send(1'b1, 2'd0, 32'h77, 1'b0, 32'h0);
        wait_rsp();
        chk("bp_wr_rdata", rsp_rdata, 32'h0);

        // Illegal addresses.
        tick(); tick();
        send(1'b0, 2'd2, 32'h0, 1'b0, 32'h0);
        @(negedge clk); chk("ill_sel_n0", {31'b0, bus_sel}, 32'h0);
        @(negedge clk);
        chk("ill_sel_n1", {31'b0, bus_sel}, 32'h0);
        chk("ill_rsp_err", {31'b0, rsp_err}, 32'h1);
        chk("ill_rsp_rdata", rsp_rdata, 32'h0);
        tick();
        send(1'b1, 2'd3, 32'hFFFF_FFFF, 1'b0, 32'h0);
        wait_rsp();
        chk("ill3_rsp_err", {31'b0, rsp_err}, 32'h1);

        // Reset while a read is waiting.
        tick(); tick();
        in_val = 32'h55;
        send(1'b0, 2'd1, 32'h0, 1'b0, 32'h0);
        tick();
        chk("rst_sel_before", {31'b0, bus_sel}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst_sel_cut", {31'b0, bus_sel}, 32'h0);
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        tick();
        rst = 1'b0;
        @(negedge clk); chk("rst_req_ready", {31'b0, req_ready}, 32'h1);
        repeat (4) begin
            @(negedge clk); chk("rst_no_rsp", {31'b0, rsp_valid}, 32'h0);
        end

        // Normal read after reset.
        tick();
        in_val = 32'hCAFE_F00D;
        send(1'b0, 2'd1, 32'h0, 1'b0, 32'h0);
        wait_rsp();
        chk("post_rst_rdata", rsp_rdata, 32'hCAFE_F00D);

`ifdef GPIO_MASTER_RMW_EN
        tick(); tick();
        in_val = 32'h0F;
        send(1'b1, 2'd1, 32'hF0, 1'b1, 32'hC0);
        repeat (2) @(negedge clk);
        chk("rmw_rd_wdata", bus_wdata, 32'h0);
        repeat (3) @(negedge clk);
        chk("rmw_wr_sel", {31'b0, bus_sel}, 32'h1);
        chk("rmw_wr_wdata", bus_wdata, 32'hCF);
        wait_rsp();
        chk("rmw_rsp_rdata", rsp_rdata, 32'h0F);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
